shot_charge_controller: RTL
===========================

Name: shot_charge_controller

Overview:
- Upstream stage of the white-ball trajectory block.
- Converts keyboard key levels into the single-cycle charge pulses (chargeUp/Down/Left/Right) and the releaseBall pulse that block consumes.
- Shadows that block's shot accumulators so it never over-charges, and only permits aiming and firing once the ball is stationary.
- Stillness is detected by watching the ball's topLeftX/topLeftY across frames.

Parameters:
- CHARGE_PERIOD_FRAMES, 4: startOfFrame pulses between auto-repeat charge pulses while a key is held.
- MAX_CHARGE_STEPS, 5: per-axis charge magnitude limit (5 x 200 = 1000 speed units).
- STILL_FRAMES, 3: consecutive frames of unchanged position that declare the ball still.

Ports:
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- startOfFrame  in  1  one-cycle pulse per frame
- keyUp, keyDown, keyLeft, keyRight  in  1 each  key-held levels from the keyboard decoder
- keyFire  in  1  fire key level
- topLeftX, topLeftY  in  11 each, signed  ball position from the trajectory block
- chargeUp, chargeDown, chargeLeft, chargeRight  out  1 each  one-cycle charge pulses
- releaseBall  out  1  one-cycle fire pulse
- ballStill  out  1  ball considered stationary
- shotPowerX, shotPowerY  out  4 each, signed  current charge steps, range -MAX..+MAX
- shotState  out  2  0=MOVING, 1=AIM, 2=FIRE

Behaviour:
- Reset values:
  - All pulse outputs 0.
  - shotPowerX/Y = 0; stillCnt = 0; prevX/prevY = 0.
  - All repeat counters 0; all keys disarmed.
  - State = MOVING; ballStill = 0.
- Stillness detection, evaluated on each startOfFrame:
  - If topLeftX==prevX and topLeftY==prevY, stillCnt increments, saturating at STILL_FRAMES; otherwise stillCnt = 0.
  - prevX/prevY are then loaded with the current position.
  - ballStill = (stillCnt == STILL_FRAMES), registered.
- FSM:
  - MOVING -> AIM when ballStill=1.
  - AIM -> FIRE on a keyFire rising edge (registered edge detect) when shotPowerX != 0 or shotPowerY != 0. A fire edge with both powers zero is ignored and the state stays AIM.
  - FIRE lasts exactly one cycle:
    - releaseBall = 1.
    - shotPowerX/Y cleared to 0.
    - stillCnt cleared to 0.
    - Next state is MOVING.
- Arming:
  - On entry to AIM, every direction key currently held is disarmed.
  - A key arms when it is seen low.
  - This prevents carried-over presses from charging.
- Charge pulse generation, AIM only, per armed key:
  - Rising edge: pulse on the next cycle and load that key's repeat counter with CHARGE_PERIOD_FRAMES.
  - While held: decrement the counter on each startOfFrame; on reaching 0, pulse and reload.
  - Release: clear the counter.
- Direction mapping: keyUp -> chargeUp with shotPowerY+1; keyDown -> chargeDown with shotPowerY-1; keyLeft -> chargeLeft with shotPowerX+1; keyRight -> chargeRight with shotPowerX-1.
- Saturation: a pulse is suppressed (no output, power unchanged) if it would take power beyond +/-MAX_CHARGE_STEPS. The repeat counter still reloads.
- Opposite keys held together on one axis: both pulses suppressed, no power change. The two axes are independent and may pulse in the same cycle.
- Outside AIM:
  - No charge pulses; key edges are ignored.
  - Powers hold their values (they are 0 in MOVING after FIRE).
- Simultaneous events: a fire edge and a charge in the same AIM cycle -> fire wins, and that charge pulse is suppressed.
- Pulse timing: every output pulse is exactly one clk wide, and at most one pulse per output per cycle.
- Mid-operation reset: resetN low returns everything to reset values immediately, including during FIRE. releaseBall drops asynchronously.

Test Plan:
- Stillness: reset, hold position (100,220), pulse startOfFrame 4 times -> ballStill=1 after the 4th frame (first frame mismatches prev 0,0; then 3 matches), shotState=1.
- Charge: in AIM, press keyUp, hold for 20 frames -> chargeUp pulses at t0+1 and every 4 frames after; exactly 5 pulses; shotPowerY=+5; further pulses suppressed.
- Fire: from shotPowerY=+5, shotPowerX=-2, keyFire rising edge -> releaseBall one-cycle high, both powers 0, shotState=0; position changing per frame keeps ballStill=0.
- Zero-power fire: in AIM with powers 0, pulse keyFire -> no releaseBall, state stays AIM.
- Arming and opposite keys: keyLeft held while entering AIM -> no chargeLeft until released and re-pressed. keyLeft+keyRight pressed together -> no pulses, shotPowerX unchanged.
- Reset mid-FIRE: assert resetN=0 in the FIRE cycle -> releaseBall=0 immediately, state MOVING, powers 0.

Source files
------------

// File: rtl/shot_charge_controller.sv
// Turns keyboard levels into single-cycle charge/fire pulses for the trajectory block,
// tracking the shot accumulators and gating aim/fire on ball stillness.
module shot_charge_controller #(
  parameter int CHARGE_PERIOD_FRAMES = 4,
  parameter int MAX_CHARGE_STEPS     = 5,
  parameter int STILL_FRAMES         = 3
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               keyUp,
  input  logic               keyDown,
  input  logic               keyLeft,
  input  logic               keyRight,
  input  logic               keyFire,
  input  logic signed [10:0] topLeftX,
  input  logic signed [10:0] topLeftY,
  output logic               chargeUp,
  output logic               chargeDown,
  output logic               chargeLeft,
  output logic               chargeRight,
  output logic               releaseBall,
  output logic               ballStill,
  output logic signed [3:0]  shotPowerX,
  output logic signed [3:0]  shotPowerY,
  output logic [1:0]         shotState
);

  localparam int CW = $clog2(CHARGE_PERIOD_FRAMES + 1);
  localparam int SW = $clog2(STILL_FRAMES + 1);
  localparam int KEY_UP = 0, KEY_DOWN = 1, KEY_LEFT = 2, KEY_RIGHT = 3;
  localparam logic signed [3:0] P_MAX = 4'(MAX_CHARGE_STEPS);
  localparam logic signed [3:0] P_MIN = -P_MAX;

  typedef enum logic [1:0] {MOVING = 2'd0, AIM = 2'd1, FIRE = 2'd2} state_t;
  typedef logic [CW-1:0] cnt_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       still_cnt_q, still_cnt_d;
  logic signed [10:0]  prev_x_q, prev_x_d, prev_y_q, prev_y_d;
  logic                ball_still_q, ball_still_d;
  logic                fire_prev_q, fire_prev_d;
  logic [3:0]          key_prev_q, key_prev_d;
  logic [3:0]          armed_q, armed_d;
  logic [3:0][CW-1:0]  rpt_cnt_q, rpt_cnt_d;
  logic [3:0]          pulse_q, pulse_d;
  logic                release_q, release_d;
  logic signed [3:0]   power_x_q, power_x_d, power_y_q, power_y_d;

  logic [3:0] keys, want, allow;
  logic       fire_edge, x_opp, y_opp;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d      = state_q;
    still_cnt_d  = still_cnt_q;
    prev_x_d     = prev_x_q;
    prev_y_d     = prev_y_q;
    armed_d      = armed_q;
    rpt_cnt_d    = '0;
    pulse_d      = '0;
    release_d    = 1'b0;
    power_x_d    = power_x_q;
    power_y_d    = power_y_q;
    want         = '0;
    keys         = {keyRight, keyLeft, keyDown, keyUp};
    key_prev_d   = keys;
    fire_prev_d  = keyFire;
    fire_edge    = keyFire & ~fire_prev_q;

    if (startOfFrame) begin
      if (topLeftX == prev_x_q && topLeftY == prev_y_q) begin
        if (still_cnt_q != SW'(STILL_FRAMES)) still_cnt_d = still_cnt_q + SW'(1);
      end else begin
        still_cnt_d = '0;
      end
      prev_x_d = topLeftX;
      prev_y_d = topLeftY;
    end

    for (int i = 0; i < 4; i++) begin
      if (!keys[i]) armed_d[i] = 1'b1;
      if (state_q == AIM && armed_q[i] && keys[i]) begin
        if (!key_prev_q[i]) begin
          want[i]      = 1'b1;
          rpt_cnt_d[i] = cnt_t'(CHARGE_PERIOD_FRAMES);
        end else if (startOfFrame && rpt_cnt_q[i] <= cnt_t'(1)) begin
          want[i]      = 1'b1;
          rpt_cnt_d[i] = cnt_t'(CHARGE_PERIOD_FRAMES);
        end else if (startOfFrame) begin
          rpt_cnt_d[i] = rpt_cnt_q[i] - cnt_t'(1);
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i];
        end
      end
    end

    // Opposite keys held together cancel each other; the repeat counters keep running.
    y_opp = keys[KEY_UP] & keys[KEY_DOWN];
    x_opp = keys[KEY_LEFT] & keys[KEY_RIGHT];
    allow[KEY_UP]    = want[KEY_UP]    && !y_opp && (power_y_q < P_MAX);
    allow[KEY_DOWN]  = want[KEY_DOWN]  && !y_opp && (power_y_q > P_MIN);
    allow[KEY_LEFT]  = want[KEY_LEFT]  && !x_opp && (power_x_q < P_MAX);
    allow[KEY_RIGHT] = want[KEY_RIGHT] && !x_opp && (power_x_q > P_MIN);

    case (state_q)
      MOVING: begin
        if (ball_still_q) begin
          state_d = AIM;
          armed_d = ~keys;
        end
      end
      AIM: begin
        if (fire_edge && (power_x_q != 4'sd0 || power_y_q != 4'sd0)) begin
          state_d   = FIRE;
          release_d = 1'b1;
        end else begin
          pulse_d = allow;
          if (allow[KEY_UP])    power_y_d = power_y_q + 4'sd1;
          if (allow[KEY_DOWN])  power_y_d = power_y_q - 4'sd1;
          if (allow[KEY_LEFT])  power_x_d = power_x_q + 4'sd1;
          if (allow[KEY_RIGHT]) power_x_d = power_x_q - 4'sd1;
        end
      end
      default: begin
        state_d     = MOVING;
        power_x_d   = '0;
        power_y_d   = '0;
        still_cnt_d = '0;
      end
    endcase

    ball_still_d = (still_cnt_d == SW'(STILL_FRAMES));
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= MOVING;
      still_cnt_q  <= '0;
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      ball_still_q <= 1'b0;
      fire_prev_q  <= 1'b0;
      key_prev_q   <= '0;
      armed_q      <= '0;
      rpt_cnt_q    <= '0;
      pulse_q      <= '0;
      release_q    <= 1'b0;
      power_x_q    <= '0;
      power_y_q    <= '0;
    end else begin
      state_q      <= state_d;
      still_cnt_q  <= still_cnt_d;
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      ball_still_q <= ball_still_d;
      fire_prev_q  <= fire_prev_d;
      key_prev_q   <= key_prev_d;
      armed_q      <= armed_d;
      rpt_cnt_q    <= rpt_cnt_d;
      pulse_q      <= pulse_d;
      release_q    <= release_d;
      power_x_q    <= power_x_d;
      power_y_q    <= power_y_d;
    end
  end

  assign chargeUp    = pulse_q[KEY_UP];
  assign chargeDown  = pulse_q[KEY_DOWN];
  assign chargeLeft  = pulse_q[KEY_LEFT];
  assign chargeRight = pulse_q[KEY_RIGHT];
  assign releaseBall = release_q;
  assign ballStill   = ball_still_q;
  assign shotPowerX  = power_x_q;
  assign shotPowerY  = power_y_q;
  assign shotState   = state_q;

endmodule
